int_ctrl: RTL and testbench

Interrupt controller between the debounced board buttons and the MIPS pipeline's single `interrupter`/`int_cause` input pair. It does the following:
- detects rising edges on N request lines and latches them as pending;
- applies a per-source mask and picks one source by fixed priority;
- drives a held request with a stable cause code until the CPU acknowledges it;
- blocks further requests until the CPU signals return from the handler (ERET).

It lives in the top level and replaces the ad-hoc level-sampled interrupt logic there.

---
 rtl/int_ctrl.sv | 106 ++++++++++
 tb/tb_int_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// Edge-triggered interrupt controller in front of the CPU's single request/cause input.
// Pending sources are latched, masked and arbitrated by fixed priority; one request is in flight until ERET.
module int_ctrl #(
  parameter int N_SRC   = 4,
  parameter int CAUSE_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_SRC-1:0]   irq_src,
  input  logic [N_SRC-1:0]   irq_mask,
  input  logic               int_ack,
  input  logic               int_eret,
  output logic               interrupter,
  output logic [CAUSE_W-1:0] int_cause,
  output logic [N_SRC-1:0]   pending,
  output logic [N_SRC-1:0]   overrun,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERV
  } state_t;

  state_t state;
  state_t state_n;

  logic [N_SRC-1:0]   irq_prev;
  logic [N_SRC-1:0]   edges;
  logic [N_SRC-1:0]   ready;
  logic [N_SRC-1:0]   ack_hot;
  logic [N_SRC-1:0]   pend_n;
  logic [N_SRC-1:0]   ovr_n;
  logic [CAUSE_W-1:0] pick;
  logic [CAUSE_W-1:0] cause_n;
  logic               irq_n;
  logic               any;

  assign edges   = irq_src & ~irq_prev;
  assign ready   = pending & irq_mask;
  assign any     = |ready;
  assign ack_hot = N_SRC'(1) << int_cause;

  // Scan high to low so the lowest set bit wins.
  always_comb begin
    pick = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (ready[i]) pick = CAUSE_W'(i);
    end
  end

  always_comb begin
    state_n = state;
    irq_n   = interrupter;
    cause_n = int_cause;
    pend_n  = pending | edges;
    ovr_n   = overrun | (edges & pending);
    unique case (state)
      IDLE: begin
        if (any) begin
          cause_n = pick;
          irq_n   = 1'b1;
          state_n = REQ;
        end
      end
      REQ: begin
        // A fresh edge on the acked line re-arms it without counting as overrun.
        if (int_ack) begin
          pend_n  = (pending & ~ack_hot) | edges;
          ovr_n   = ovr_n & ~ack_hot;
          irq_n   = 1'b0;
          state_n = SERV;
        end
      end
      SERV: begin
        if (int_eret) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        irq_n   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      irq_prev    <= '1;
      pending     <= '0;
      overrun     <= '0;
      interrupter <= 1'b0;
      int_cause   <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      irq_prev    <= irq_src;
      pending     <= pend_n;
      overrun     <= ovr_n;
      interrupter <= irq_n;
      int_cause   <= cause_n;
      busy        <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: delivery, priority, masking,
// overrun, ignored handshakes and reset behaviour.
module tb_int_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] irq_src;
  logic [3:0] irq_mask;
  logic       int_ack;
  logic       int_eret;
  logic       interrupter;
  logic [1:0] int_cause;
  logic [3:0] pending;
  logic [3:0] overrun;
  logic       busy;

  int cmp = 0;
  int err = 0;

  int_ctrl #(.N_SRC(4), .CAUSE_W(2)) dut (
    .clk(clk),
    .rst(rst),
    .irq_src(irq_src),
    .irq_mask(irq_mask),
    .int_ack(int_ack),
    .int_eret(int_eret),
    .interrupter(interrupter),
    .int_cause(int_cause),
    .pending(pending),
    .overrun(overrun),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; irq_src = '0; irq_mask = 4'hF;
    int_ack = 1'b0; int_eret = 1'b0;
    tick(); tick(); tick();
    cmp++; if (interrupter !== 1'b0) begin err++; $display("FAIL rst_irq: got %b want 0", interrupter); end
    cmp++; if (int_cause !== 2'd0) begin err++; $display("FAIL rst_cause: got %0d want 0", int_cause); end
    cmp++; if (pending !== 4'b0000) begin err++; $display("FAIL rst_pend: got %b want 0000", pending); end
    cmp++; if (overrun !== 4'b0000) begin err++; $display("FAIL rst_ovr: got %b want 0000", overrun); end
    cmp++; if (busy !== 1'b0) begin err++; $display("FAIL rst_busy: got %b want 0", busy); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    irq_src = 4'b0010;
    tick();
    cmp++; if (pending !== 4'b0010) begin err++; $display("FAIL t1_pend: got %b want 0010", pending); end
    cmp++; if (interrupter !== 1'b0) begin err++; $display("FAIL t1_early: got %b want 0", interrupter); end
    tick();
    cmp++; if (interrupter !== 1'b1) begin err++; $display("FAIL t1_irq: got %b want 1", interrupter); end
    cmp++; if (int_cause !== 2'd1) begin err++; $display("FAIL t1_cause: got %0d want 1", int_cause); end
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    cmp++; if (interrupter !== 1'b0) begin err++; $display("FAIL t1_ack_irq: got %b want 0", interrupter); end
    cmp++; if (pending !== 4'b0000) begin err++; $display("FAIL t1_ack_pend: got %b want 0000", pending); end
    cmp++; if (busy !== 1'b1) begin err++; $display("FAIL t1_ack_busy: got %b want 1", busy); end
    tick();
    irq_src = 4'b0000;
    int_eret = 1'b1; tick(); int_eret = 1'b0;
    cmp++; if (busy !== 1'b0) begin err++; $display("FAIL t1_eret_busy: got %b want 0", busy); end
    tick();
  endtask

  task automatic test_priority();
    irq_src = 4'b1001;
    tick();
    cmp++; if (pending !== 4'b1001) begin err++; $display("FAIL t2_pend: got %b want 1001", pending); end
    tick();
    cmp++; if (int_cause !== 2'd0 || interrupter !== 1'b1) begin err++; $display("FAIL t2_first: got irq=%b cause=%0d want irq=1 cause=0", interrupter, int_cause); end
    irq_mask = 4'h0;
    tick();
    irq_mask = 4'hF;
    cmp++; if (int_cause !== 2'd0 || interrupter !== 1'b1) begin err++; $display("FAIL t2_hold: got irq=%b cause=%0d want irq=1 cause=0", interrupter, int_cause); end
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    cmp++; if (pending !== 4'b1000) begin err++; $display("FAIL t2_left: got %b want 1000", pending); end
    int_eret = 1'b1; tick(); int_eret = 1'b0;
    cmp++; if (busy !== 1'b0 || interrupter !== 1'b0) begin err++; $display("FAIL t2_eret: got busy=%b irq=%b want 0 0", busy, interrupter); end
    tick();
    cmp++; if (int_cause !== 2'd3 || interrupter !== 1'b1) begin err++; $display("FAIL t2_second: got irq=%b cause=%0d want irq=1 cause=3", interrupter, int_cause); end
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    int_eret = 1'b1; tick(); int_eret = 1'b0;
    irq_src = 4'b0000;
    tick();
  endtask

  task automatic test_mask();
    irq_mask = 4'b1110;
    irq_src = 4'b0001;
    tick();
    cmp++; if (pending !== 4'b0001) begin err++; $display("FAIL t3_pend: got %b want 0001", pending); end
    for (int i = 0; i < 20; i++) begin
      tick();
      cmp++; if (interrupter !== 1'b0) begin err++; $display("FAIL t3_masked: cycle %0d got %b want 0", i, interrupter); end
    end
    irq_mask = 4'hF;
    tick();
    cmp++; if (interrupter !== 1'b1 || int_cause !== 2'd0) begin err++; $display("FAIL t3_unmask: got irq=%b cause=%0d want irq=1 cause=0", interrupter, int_cause); end
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    int_eret = 1'b1; tick(); int_eret = 1'b0;
    irq_src = 4'b0000;
    tick();
  endtask

  task automatic test_overrun();
    irq_src = 4'b0100; tick();
    irq_src = 4'b0000; tick();
    cmp++; if (interrupter !== 1'b1 || int_cause !== 2'd2) begin err++; $display("FAIL t4_irq: got irq=%b cause=%0d want irq=1 cause=2", interrupter, int_cause); end
    irq_src = 4'b0100; tick();
    cmp++; if (overrun !== 4'b0100) begin err++; $display("FAIL t4_ovr: got %b want 0100", overrun); end
    irq_src = 4'b0000; tick();
    irq_src = 4'b0100;
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    cmp++; if (pending !== 4'b0100) begin err++; $display("FAIL t4_coinc_pend: got %b want 0100", pending); end
    cmp++; if (overrun !== 4'b0000) begin err++; $display("FAIL t4_coinc_ovr: got %b want 0000", overrun); end
    cmp++; if (interrupter !== 1'b0 || busy !== 1'b1) begin err++; $display("FAIL t4_serv: got irq=%b busy=%b want 0 1", interrupter, busy); end
    int_eret = 1'b1; tick(); int_eret = 1'b0;
    tick();
    cmp++; if (interrupter !== 1'b1 || int_cause !== 2'd2) begin err++; $display("FAIL t4_redeliver: got irq=%b cause=%0d want irq=1 cause=2", interrupter, int_cause); end
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    cmp++; if (pending !== 4'b0000) begin err++; $display("FAIL t4_clear: got %b want 0000", pending); end
    int_eret = 1'b1; tick(); int_eret = 1'b0;
    irq_src = 4'b0000;
    tick();
  endtask

  task automatic test_handshake_reset();
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    cmp++; if (busy !== 1'b0 || interrupter !== 1'b0) begin err++; $display("FAIL t5_idle_ack: got busy=%b irq=%b want 0 0", busy, interrupter); end
    irq_src = 4'b0010; tick();
    irq_src = 4'b0000; tick();
    int_eret = 1'b1; tick(); int_eret = 1'b0;
    cmp++; if (interrupter !== 1'b1 || busy !== 1'b1) begin err++; $display("FAIL t5_req_eret: got irq=%b busy=%b want 1 1", interrupter, busy); end
    int_ack = 1'b1; int_eret = 1'b1; tick();
    int_ack = 1'b0; int_eret = 1'b0;
    cmp++; if (busy !== 1'b1 || interrupter !== 1'b0) begin err++; $display("FAIL t5_ack_eret: got busy=%b irq=%b want 1 0", busy, interrupter); end
    irq_src = 4'b0110; tick();
    cmp++; if (pending !== 4'b0110) begin err++; $display("FAIL t5_serv_pend: got %b want 0110", pending); end
    rst = 1'b1; tick();
    cmp++; if ({interrupter, int_cause, pending, overrun, busy} !== 12'd0) begin err++; $display("FAIL t5_rst: got irq=%b cause=%0d pend=%b ovr=%b busy=%b want all 0", interrupter, int_cause, pending, overrun, busy); end
    rst = 1'b0; tick(); tick(); tick();
    cmp++; if (pending !== 4'b0000 || interrupter !== 1'b0) begin err++; $display("FAIL t5_held: got pend=%b irq=%b want 0000 0", pending, interrupter); end
    irq_src = 4'b0000; tick();
    irq_src = 4'b0010; tick();
    cmp++; if (pending !== 4'b0010) begin err++; $display("FAIL t5_rerise: got %b want 0010", pending); end
    tick();
    cmp++; if (interrupter !== 1'b1 || int_cause !== 2'd1) begin err++; $display("FAIL t5_deliver: got irq=%b cause=%0d want irq=1 cause=1", interrupter, int_cause); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_overrun();
    test_handshake_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

endmodule
